// File: rtl/seven_seg_capture.sv
// Recovers the value shown on a 4-digit multiplexed, active-low seven-segment display
// by sampling its digit-enable and segment lines and assembling complete scans into BCD.
module seven_seg_capture #(
    parameter int unsigned STABLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65536
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  DIGIT,
    input  logic [0:6]  DISPLAY,
    output logic [15:0] bcd,
    output logic        frame_valid,
    output logic        frame_done,
    output logic        seg_err,
    output logic        seq_err
);

    localparam int unsigned SCW = $clog2(STABLE_CYCLES + 1);
    localparam int unsigned TCW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        HUNT = 2'd0,
        D1   = 2'd1,
        D2   = 2'd2,
        D3   = 2'd3
    } state_t;

    logic [3:0]     r_dig_s1;
    logic [3:0]     r_dig_s2;
    logic [0:6]     r_seg_s1;
    logic [0:6]     r_seg_s2;

    logic [3:0]     r_prev_dig;
    logic [0:6]     r_prev_seg;
    logic [SCW-1:0] r_stab_cnt;
    logic           r_acc;

    logic [TCW-1:0] r_to_cnt;

    state_t         r_state;
    logic [11:0]    r_partial;
    logic [15:0]    r_bcd;
    logic           r_frame_valid;
    logic           r_frame_done;
    logic           r_seg_err;
    logic           r_seq_err;

    logic           w_changed;
    logic [SCW-1:0] w_stab_next;
    logic           w_acc_next;

    logic           w_blank;
    logic           w_onehot;
    logic [1:0]     w_idx;
    logic           w_seg_ok;
    logic [3:0]     w_val;
    logic           w_hit;
    logic           w_timeout;

    state_t         w_state_next;
    logic [11:0]    w_partial_next;
    logic           w_load;
    logic           w_seg_err;
    logic           w_seq_err;
    logic           w_misorder;

    // Two-flop synchronizer; idle lines are high, so reset to all ones
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dig_s1 <= '1;
            r_dig_s2 <= '1;
            r_seg_s1 <= '1;
            r_seg_s2 <= '1;
        end else begin
            r_dig_s1 <= DIGIT;
            r_dig_s2 <= r_dig_s1;
            r_seg_s1 <= DISPLAY;
            r_seg_s2 <= r_seg_s1;
        end
    end

    assign w_changed = (r_dig_s2 != r_prev_dig) || (r_seg_s2 != r_prev_seg);

    always_comb begin
        w_stab_next = r_stab_cnt;
        if (w_changed) begin
            w_stab_next = SCW'(1);
        end else if (r_stab_cnt != SCW'(STABLE_CYCLES)) begin
            w_stab_next = r_stab_cnt + SCW'(1);
        end
        // Fire only on the sample that reaches the threshold, never while saturated
        w_acc_next = (w_stab_next == SCW'(STABLE_CYCLES)) &&
                     (w_changed || (r_stab_cnt != SCW'(STABLE_CYCLES)));
    end

    // r_prev_* holds the accepted pattern during the cycle r_acc is high
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev_dig <= '1;
            r_prev_seg <= '1;
            r_stab_cnt <= '0;
            r_acc      <= 1'b0;
        end else begin
            r_prev_dig <= r_dig_s2;
            r_prev_seg <= r_seg_s2;
            r_stab_cnt <= w_stab_next;
            r_acc      <= w_acc_next;
        end
    end

    always_comb begin
        w_onehot = 1'b1;
        w_idx    = 2'd0;
        case (r_prev_dig)
            4'b1110: w_idx = 2'd0;
            4'b1101: w_idx = 2'd1;
            4'b1011: w_idx = 2'd2;
            4'b0111: w_idx = 2'd3;
            default: w_onehot = 1'b0;
        endcase
    end

    always_comb begin
        w_seg_ok = 1'b1;
        w_val    = 4'd0;
        case (r_prev_seg)
            7'b0000001: w_val = 4'd0;
            7'b1001111: w_val = 4'd1;
            7'b0010010: w_val = 4'd2;
            7'b0000110: w_val = 4'd3;
            7'b1001100: w_val = 4'd4;
            7'b0100100: w_val = 4'd5;
            7'b0100000: w_val = 4'd6;
            7'b0001111: w_val = 4'd7;
            7'b0000000: w_val = 4'd8;
            7'b0000100: w_val = 4'd9;
            default:    w_seg_ok = 1'b0;
        endcase
    end

    assign w_blank   = (r_prev_dig == 4'b1111);
    assign w_hit     = r_acc && !w_blank;
    assign w_timeout = !w_hit && (r_to_cnt == TCW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        w_state_next   = r_state;
        w_partial_next = r_partial;
        w_load         = 1'b0;
        w_seg_err      = 1'b0;
        w_seq_err      = 1'b0;
        w_misorder     = 1'b0;
        if (w_hit) begin
            if (!w_onehot) begin
                w_seq_err    = 1'b1;
                w_state_next = HUNT;
            end else if (!w_seg_ok) begin
                w_seg_err    = 1'b1;
                w_state_next = HUNT;
            end else begin
                case (r_state)
                    HUNT: begin
                        if (w_idx == 2'd0) begin
                            w_partial_next = {8'h00, w_val};
                            w_state_next   = D1;
                        end
                    end
                    D1: begin
                        if (w_idx == 2'd1) begin
                            w_partial_next[7:4] = w_val;
                            w_state_next        = D2;
                        end else begin
                            w_misorder = 1'b1;
                        end
                    end
                    D2: begin
                        if (w_idx == 2'd2) begin
                            w_partial_next[11:8] = w_val;
                            w_state_next         = D3;
                        end else begin
                            w_misorder = 1'b1;
                        end
                    end
                    D3: begin
                        if (w_idx == 2'd3) begin
                            w_load       = 1'b1;
                            w_state_next = HUNT;
                        end else begin
                            w_misorder = 1'b1;
                        end
                    end
                    default: w_state_next = HUNT;
                endcase
                // A stray digit0 is treated as the start of a fresh scan
                if (w_misorder) begin
                    w_seq_err = 1'b1;
                    if (w_idx == 2'd0) begin
                        w_partial_next = {8'h00, w_val};
                        w_state_next   = D1;
                    end else begin
                        w_state_next = HUNT;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_to_cnt <= '0;
        end else if (w_hit) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TCW'(TIMEOUT_CYCLES)) begin
            r_to_cnt <= r_to_cnt + TCW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= HUNT;
            r_partial     <= '0;
            r_bcd         <= '0;
            r_frame_valid <= 1'b0;
            r_frame_done  <= 1'b0;
            r_seg_err     <= 1'b0;
            r_seq_err     <= 1'b0;
        end else begin
            r_state      <= w_timeout ? HUNT : w_state_next;
            r_partial    <= w_partial_next;
            r_frame_done <= w_load;
            r_seg_err    <= w_seg_err;
            r_seq_err    <= w_seq_err;
            if (w_load) begin
                r_bcd         <= {w_val, r_partial};
                r_frame_valid <= 1'b1;
            end else if (w_timeout) begin
                r_frame_valid <= 1'b0;
            end
        end
    end

    assign bcd         = r_bcd;
    assign frame_valid = r_frame_valid;
    assign frame_done  = r_frame_done;
    assign seg_err     = r_seg_err;
    assign seq_err     = r_seq_err;

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: scans, glitches, error cases, timeout and reset.
module tb_seven_seg_capture;

    localparam int unsigned S = 4;
    localparam int unsigned T = 20000;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  DIGIT;
    logic [0:6]  DISPLAY;
    logic [15:0] bcd;
    logic        frame_valid;
    logic        frame_done;
    logic        seg_err;
    logic        seq_err;

    int n_chk  = 0;
    int n_pass = 0;
    int n_done = 0;
    int n_seg  = 0;
    int n_seq  = 0;

    seven_seg_capture #(
        .STABLE_CYCLES  (S),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .DIGIT       (DIGIT),
        .DISPLAY     (DISPLAY),
        .bcd         (bcd),
        .frame_valid (frame_valid),
        .frame_done  (frame_done),
        .seg_err     (seg_err),
        .seq_err     (seq_err)
    );

    always #5 clk = ~clk;

    // Counts high cycles, so a stretched pulse shows up as an extra count
    always @(negedge clk) begin
        if (frame_done) n_done++;
        if (seg_err)    n_seg++;
        if (seq_err)    n_seq++;
    end

    function automatic logic [0:6] seg_of(input int d);
        case (d)
            0:       return 7'b0000001;
            1:       return 7'b1001111;
            2:       return 7'b0010010;
            3:       return 7'b0000110;
            4:       return 7'b1001100;
            5:       return 7'b0100100;
            6:       return 7'b0100000;
            7:       return 7'b0001111;
            8:       return 7'b0000000;
            9:       return 7'b0000100;
            default: return 7'b1111111;
        endcase
    endfunction

    // Tasks start and end 1 time unit after a rising edge
    task automatic drive(input logic [3:0] dig, input logic [0:6] seg, input int n);
        DIGIT   = dig;
        DISPLAY = seg;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show(input int idx, input logic [0:6] seg, input int n);
        logic [3:0] d;
        d      = 4'b1111;
        d[idx] = 1'b0;
        drive(d, seg, n);
    endtask

    task automatic test_reset;
        reset   = 1'b1;
        DIGIT   = 4'b1111;
        DISPLAY = 7'b1111111;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        n_chk++; if (bcd !== 16'h0000) $display("FAIL reset_bcd got=%h exp=0000", bcd); else n_pass++;
        n_chk++; if (frame_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", frame_valid); else n_pass++;
        n_chk++; if (frame_done !== 1'b0) $display("FAIL reset_done got=%b exp=0", frame_done); else n_pass++;
        n_chk++; if (seg_err !== 1'b0) $display("FAIL reset_seg_err got=%b exp=0", seg_err); else n_pass++;
        n_chk++; if (seq_err !== 1'b0) $display("FAIL reset_seq_err got=%b exp=0", seq_err); else n_pass++;
        reset = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic_frame;
        int d0, s0, q0, lat;
        d0 = n_done; s0 = n_seg; q0 = n_seq; lat = 0;
        show(0, seg_of(4), 8192);
        show(1, seg_of(3), 8192);
        show(2, seg_of(2), 8192);
        show(3, seg_of(1), 0);
        for (int k = 1; k <= 8192; k++) begin
            @(posedge clk);
            #1;
            if (frame_done && lat == 0) lat = k;
        end
        n_chk++; if (lat !== 7) $display("FAIL basic_latency got=%0d exp=7", lat); else n_pass++;
        n_chk++; if (n_done - d0 !== 1) $display("FAIL basic_done_count got=%0d exp=1", n_done - d0); else n_pass++;
        n_chk++; if (bcd !== 16'h1234) $display("FAIL basic_bcd got=%h exp=1234", bcd); else n_pass++;
        n_chk++; if (frame_valid !== 1'b1) $display("FAIL basic_valid got=%b exp=1", frame_valid); else n_pass++;
        n_chk++; if (n_seg - s0 + n_seq - q0 !== 0) $display("FAIL basic_errors got=%0d exp=0", n_seg - s0 + n_seq - q0); else n_pass++;
    endtask

    task automatic test_glitch;
        int d0, s0, q0;
        d0 = n_done; s0 = n_seg; q0 = n_seq;
        for (int i = 0; i < 4; i++) begin
            show(i, 7'b1111111, 1);
            show(i, 7'b0000000, 1);
            show(i, seg_of(4 - i), 12);
        end
        n_chk++; if (n_done - d0 !== 1) $display("FAIL glitch_done_count got=%0d exp=1", n_done - d0); else n_pass++;
        n_chk++; if (n_seg - s0 !== 0) $display("FAIL glitch_seg_err got=%0d exp=0", n_seg - s0); else n_pass++;
        n_chk++; if (n_seq - q0 !== 0) $display("FAIL glitch_seq_err got=%0d exp=0", n_seq - q0); else n_pass++;
        n_chk++; if (bcd !== 16'h1234) $display("FAIL glitch_bcd got=%h exp=1234", bcd); else n_pass++;
    endtask

    task automatic test_seg_err;
        int d0, s0, q0;
        d0 = n_done; s0 = n_seg; q0 = n_seq;
        show(0, seg_of(5), 12);
        show(1, 7'b1111111, 12);
        show(2, seg_of(7), 12);
        show(3, seg_of(8), 12);
        n_chk++; if (n_seg - s0 !== 1) $display("FAIL seg_err_pulse got=%0d exp=1", n_seg - s0); else n_pass++;
        n_chk++; if (n_done - d0 !== 0) $display("FAIL seg_err_no_done got=%0d exp=0", n_done - d0); else n_pass++;
        n_chk++; if (n_seq - q0 !== 0) $display("FAIL seg_err_no_seq got=%0d exp=0", n_seq - q0); else n_pass++;
        n_chk++; if (bcd !== 16'h1234) $display("FAIL seg_err_bcd_kept got=%h exp=1234", bcd); else n_pass++;
        n_chk++; if (frame_valid !== 1'b1) $display("FAIL seg_err_valid_kept got=%b exp=1", frame_valid); else n_pass++;
        d0 = n_done;
        for (int i = 0; i < 4; i++) show(i, seg_of(5 + i), 12);
        n_chk++; if (n_done - d0 !== 1) $display("FAIL seg_err_rescan_done got=%0d exp=1", n_done - d0); else n_pass++;
        n_chk++; if (bcd !== 16'h8765) $display("FAIL seg_err_rescan_bcd got=%h exp=8765", bcd); else n_pass++;
    endtask

    task automatic test_seq_err;
        int d0, s0, q0;
        d0 = n_done; s0 = n_seg; q0 = n_seq;
        show(0, seg_of(9), 12);
        drive(4'b1100, seg_of(0), 12);
        show(1, seg_of(1), 12);
        show(2, seg_of(2), 12);
        show(3, seg_of(3), 12);
        n_chk++; if (n_seq - q0 !== 1) $display("FAIL seq_illegal_pulse got=%0d exp=1", n_seq - q0); else n_pass++;
        n_chk++; if (n_done - d0 !== 0) $display("FAIL seq_illegal_hunt got=%0d exp=0", n_done - d0); else n_pass++;
        q0 = n_seq;
        show(0, seg_of(1), 12);
        show(2, seg_of(3), 12);
        show(3, seg_of(4), 12);
        n_chk++; if (n_seq - q0 !== 1) $display("FAIL seq_skip_pulse got=%0d exp=1", n_seq - q0); else n_pass++;
        n_chk++; if (n_done - d0 !== 0) $display("FAIL seq_skip_no_done got=%0d exp=0", n_done - d0); else n_pass++;
        n_chk++; if (n_seg - s0 !== 0) $display("FAIL seq_no_seg_err got=%0d exp=0", n_seg - s0); else n_pass++;
        n_chk++; if (bcd !== 16'h8765) $display("FAIL seq_bcd_kept got=%h exp=8765", bcd); else n_pass++;
    endtask

    task automatic test_restart;
        int d0, q0;
        d0 = n_done; q0 = n_seq;
        show(0, seg_of(1), 12);
        show(0, seg_of(2), 12);
        show(1, seg_of(3), 12);
        show(2, seg_of(4), 12);
        show(3, seg_of(5), 12);
        n_chk++; if (n_seq - q0 !== 1) $display("FAIL restart_seq_err got=%0d exp=1", n_seq - q0); else n_pass++;
        n_chk++; if (n_done - d0 !== 1) $display("FAIL restart_done got=%0d exp=1", n_done - d0); else n_pass++;
        n_chk++; if (bcd !== 16'h5432) $display("FAIL restart_bcd got=%h exp=5432", bcd); else n_pass++;
    endtask

    task automatic test_timeout;
        int d0, fall;
        logic got;
        d0 = n_done; fall = 0; got = 1'b0;
        show(0, seg_of(5), 12);
        show(1, seg_of(6), 12);
        show(2, seg_of(7), 12);
        show(3, seg_of(8), 0);
        for (int k = 0; k < 50 && !got; k++) begin
            @(posedge clk);
            #1;
            if (frame_done) got = 1'b1;
        end
        n_chk++; if (got !== 1'b1) $display("FAIL timeout_frame_seen got=%b exp=1", got); else n_pass++;
        drive(4'b1111, 7'b1111111, 0);
        for (int n = 1; n <= int'(T) + 10; n++) begin
            @(posedge clk);
            #1;
            if (!frame_valid && fall == 0) fall = n;
        end
        n_chk++; if (fall !== int'(T)) $display("FAIL timeout_fall_cycle got=%0d exp=%0d", fall, T); else n_pass++;
        n_chk++; if (frame_valid !== 1'b0) $display("FAIL timeout_valid got=%b exp=0", frame_valid); else n_pass++;
        n_chk++; if (bcd !== 16'h8765) $display("FAIL timeout_bcd_kept got=%h exp=8765", bcd); else n_pass++;
        n_chk++; if (n_done - d0 !== 1) $display("FAIL timeout_done_count got=%0d exp=1", n_done - d0); else n_pass++;
    endtask

    task automatic test_reset_midframe;
        int d0, q0;
        show(0, seg_of(1), 12);
        show(1, seg_of(2), 12);
        reset = 1'b1;
        drive(4'b1111, 7'b1111111, 3);
        n_chk++; if (bcd !== 16'h0000) $display("FAIL midreset_bcd got=%h exp=0000", bcd); else n_pass++;
        n_chk++; if (frame_valid !== 1'b0) $display("FAIL midreset_valid got=%b exp=0", frame_valid); else n_pass++;
        reset = 1'b0;
        d0 = n_done; q0 = n_seq;
        show(2, seg_of(9), 12);
        show(3, seg_of(9), 12);
        n_chk++; if (n_done - d0 !== 0) $display("FAIL midreset_no_carry got=%0d exp=0", n_done - d0); else n_pass++;
        for (int i = 0; i < 4; i++) show(i, seg_of(9), 12);
        n_chk++; if (n_done - d0 !== 1) $display("FAIL midreset_done got=%0d exp=1", n_done - d0); else n_pass++;
        n_chk++; if (bcd !== 16'h9999) $display("FAIL midreset_bcd_new got=%h exp=9999", bcd); else n_pass++;
        n_chk++; if (frame_valid !== 1'b1) $display("FAIL midreset_valid_new got=%b exp=1", frame_valid); else n_pass++;
        n_chk++; if (n_seq - q0 !== 0) $display("FAIL midreset_seq_err got=%0d exp=0", n_seq - q0); else n_pass++;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_basic_frame;
        test_glitch;
        test_seg_err;
        test_seq_err;
        test_restart;
        test_timeout;
        test_reset_midframe;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
